// File: rtl/hms_ctrl_if.sv
// hms_ctrl_if: bundles the pushbuttons, the counter-bank wrap flags and every
// mode/position/count-clock output of the clock/alarm/stopwatch control front end.
// The stimulus side uses the master modport; hms_ctrl uses the slave modport.
interface hms_ctrl_if;
  // raw buttons: [0] mode, [1] position / stopwatch start-stop, [2] increment, [3] alarm toggle
  logic [3:0] i_sw;
  // wrap flags coming back from the counter bank
  logic       i_max_hit_sec;
  logic       i_max_hit_min;
  logic       i_sw_hit_ssec;
  logic       i_sw_hit_sec;
  // control state
  logic [1:0] o_mode;
  logic [1:0] o_position;
  logic       o_alarm_en;
  logic       o_stopwatch_en;
  // count clocks into the counter bank
  logic       o_sec_clk;
  logic       o_min_clk;
  logic       o_hour_clk;
  logic       o_alarm_sec_clk;
  logic       o_alarm_min_clk;
  logic       o_alarm_hour_clk;
  logic       o_sw_ssec_clk;
  logic       o_sw_sec_clk;
  logic       o_sw_min_clk;

  modport master (
    output i_sw, i_max_hit_sec, i_max_hit_min, i_sw_hit_ssec, i_sw_hit_sec,
    input  o_mode, o_position, o_alarm_en, o_stopwatch_en,
    input  o_sec_clk, o_min_clk, o_hour_clk,
    input  o_alarm_sec_clk, o_alarm_min_clk, o_alarm_hour_clk,
    input  o_sw_ssec_clk, o_sw_sec_clk, o_sw_min_clk
  );

  modport slave (
    input  i_sw, i_max_hit_sec, i_max_hit_min, i_sw_hit_ssec, i_sw_hit_sec,
    output o_mode, o_position, o_alarm_en, o_stopwatch_en,
    output o_sec_clk, o_min_clk, o_hour_clk,
    output o_alarm_sec_clk, o_alarm_min_clk, o_alarm_hour_clk,
    output o_sw_ssec_clk, o_sw_sec_clk, o_sw_min_clk
  );
endinterface

// File: rtl/hms_ctrl.sv
// hms_ctrl: control front end for the clock/alarm/stopwatch datapath.
// Debounces four buttons, owns mode/position/alarm/stopwatch state, generates the
// 1 Hz and 100 Hz ticks and drives every count clock of the counter bank, closing
// the carry chain from the counters' wrap flags.
// Optional build macro: HOLD_REPEAT_EN -- holding the increment button produces
// auto-repeat increments after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
module hms_ctrl #(
  parameter int SEC_DIV       = 50000000,
  parameter int SSEC_DIV      = 500000,
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  hms_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2,
    MODE_SW    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  localparam int SEC_W  = (SEC_DIV    > 1) ? $clog2(SEC_DIV)    : 1;
  localparam int SSEC_W = (SSEC_DIV   > 1) ? $clog2(SSEC_DIV)   : 1;
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  // index of each count clock inside the registered output vector
  localparam int OC_SEC    = 0;
  localparam int OC_MIN    = 1;
  localparam int OC_HOUR   = 2;
  localparam int OC_A_SEC  = 3;
  localparam int OC_A_MIN  = 4;
  localparam int OC_A_HOUR = 5;
  localparam int OC_SW_SS  = 6;
  localparam int OC_SW_SEC = 7;
  localparam int OC_SW_MIN = 8;

  // ---------------------------------------------------------------------------
  // Tick generators
  // ---------------------------------------------------------------------------
  logic [SEC_W-1:0]  sec_cnt_q;
  logic [SSEC_W-1:0] ssec_cnt_q;
  logic              sec_tick;
  logic              ssec_tick;

  assign sec_tick  = (sec_cnt_q  == SEC_W'(SEC_DIV - 1));
  assign ssec_tick = (ssec_cnt_q == SSEC_W'(SSEC_DIV - 1));

  // free-running dividers; each wraps to 0 in the cycle after its tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_q  <= '0;
      ssec_cnt_q <= '0;
    end else begin
      sec_cnt_q  <= sec_tick  ? '0 : sec_cnt_q  + SEC_W'(1);
      ssec_cnt_q <= ssec_tick ? '0 : ssec_cnt_q + SSEC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Button debounce: 2-flop synchronizer, stability counter, rising-edge press
  // ---------------------------------------------------------------------------
  logic [3:0] press;

  for (genvar gi = 0; gi < 4; gi++) begin : g_deb
    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    // accept the synchronized level only after DEB_CYCLES differing cycles in a row
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
          level_d = sync2_q;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
    end

    // synchronizer, debounced level and its previous value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        cnt_q        <= '0;
      end else begin
        sync1_q      <= bus.i_sw[gi];
        sync2_q      <= sync1_q;
        level_q      <= level_d;
        level_prev_q <= level_q;
        cnt_q        <= cnt_d;
      end
    end

    assign press[gi] = level_q & ~level_prev_q;
  end

  // ---------------------------------------------------------------------------
  // Increment source (single press, optionally with hold-to-repeat)
  // ---------------------------------------------------------------------------
  logic inc;

`ifdef HOLD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q;
  logic [REP_W-1:0] rep_cnt_d;
  logic             rep_armed_q;
  logic             rep_armed_d;
  logic             rep_pulse;

  // while the increment button is held: first repeat after the delay, then periodic
  always_comb begin
    rep_cnt_d   = '0;
    rep_armed_d = 1'b0;
    rep_pulse   = 1'b0;
    if (g_deb[2].level_q) begin
      rep_armed_d = rep_armed_q;
      rep_cnt_d   = rep_cnt_q + REP_W'(1);
      if (!rep_armed_q && (rep_cnt_q == REP_W'(REPEAT_DELAY - 1))) begin
        rep_pulse   = 1'b1;
        rep_armed_d = 1'b1;
        rep_cnt_d   = '0;
      end else if (rep_armed_q && (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1))) begin
        rep_pulse = 1'b1;
        rep_cnt_d = '0;
      end
    end
  end

  // repeat timer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end

  assign inc = press[2] | rep_pulse;
`else
  assign inc = press[2];
`endif

  // ---------------------------------------------------------------------------
  // Wrap-flag edge detection (flags come from this clock domain)
  // ---------------------------------------------------------------------------
  logic [3:0] hit_cur;
  logic [3:0] hit_prev_q;
  logic [3:0] rise;

  assign hit_cur = {bus.i_sw_hit_sec, bus.i_sw_hit_ssec, bus.i_max_hit_min, bus.i_max_hit_sec};
  assign rise    = hit_cur & ~hit_prev_q;

  // previous flag values, tracked in every mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_prev_q <= '0;
    end else begin
      hit_prev_q <= hit_cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode/position state machine and count-clock generation
  // ---------------------------------------------------------------------------
  mode_e      mode_q;
  mode_e      mode_d;
  pos_e       pos_q;
  pos_e       pos_d;
  logic       alarm_en_q;
  logic       alarm_en_d;
  logic       sw_stopped_q;
  logic       sw_stopped_d;
  logic [8:0] oclk_q;
  logic [8:0] oclk_d;
  logic       setup;

  assign setup = (mode_q == MODE_SETUP);

  // next state and next count clocks, all decided from the current registered mode/position
  always_comb begin
    mode_d       = mode_q;
    pos_d        = pos_q;
    alarm_en_d   = alarm_en_q ^ press[3];
    sw_stopped_d = sw_stopped_q;
    oclk_d       = '0;

    // a mode press overrides a same-cycle position press
    if (press[0]) begin
      mode_d = mode_e'(mode_q + 2'd1);
      pos_d  = POS_SEC;
    end else if (press[1]) begin
      case (mode_q)
        MODE_SETUP, MODE_ALARM: pos_d = (pos_q == POS_HOUR) ? POS_SEC : pos_e'(pos_q + 2'd1);
        MODE_SW:                sw_stopped_d = ~sw_stopped_q;
        default:                ;
      endcase
    end

    // time of day: ticks and carries run outside SETUP, increments only inside it
    oclk_d[OC_SEC]    = (~setup & sec_tick) | (setup & (pos_q == POS_SEC)  & inc);
    oclk_d[OC_MIN]    = (~setup & rise[0])  | (setup & (pos_q == POS_MIN)  & inc);
    oclk_d[OC_HOUR]   = (~setup & rise[1])  | (setup & (pos_q == POS_HOUR) & inc);
    // alarm registers only move by manual increment
    oclk_d[OC_A_SEC]  = (mode_q == MODE_ALARM) & (pos_q == POS_SEC)  & inc;
    oclk_d[OC_A_MIN]  = (mode_q == MODE_ALARM) & (pos_q == POS_MIN)  & inc;
    oclk_d[OC_A_HOUR] = (mode_q == MODE_ALARM) & (pos_q == POS_HOUR) & inc;
    // stopwatch keeps running whatever mode is displayed
    oclk_d[OC_SW_SS]  = ssec_tick & ~sw_stopped_q;
    oclk_d[OC_SW_SEC] = rise[2];
    oclk_d[OC_SW_MIN] = rise[3];
  end

  // control state and registered count clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_CLOCK;
      pos_q        <= POS_SEC;
      alarm_en_q   <= 1'b0;
      sw_stopped_q <= 1'b1;
      oclk_q       <= '0;
    end else begin
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      alarm_en_q   <= alarm_en_d;
      sw_stopped_q <= sw_stopped_d;
      oclk_q       <= oclk_d;
    end
  end

  assign bus.o_mode           = mode_q;
  assign bus.o_position       = pos_q;
  assign bus.o_alarm_en       = alarm_en_q;
  assign bus.o_stopwatch_en   = sw_stopped_q;
  assign bus.o_sec_clk        = oclk_q[OC_SEC];
  assign bus.o_min_clk        = oclk_q[OC_MIN];
  assign bus.o_hour_clk       = oclk_q[OC_HOUR];
  assign bus.o_alarm_sec_clk  = oclk_q[OC_A_SEC];
  assign bus.o_alarm_min_clk  = oclk_q[OC_A_MIN];
  assign bus.o_alarm_hour_clk = oclk_q[OC_A_HOUR];
  assign bus.o_sw_ssec_clk    = oclk_q[OC_SW_SS];
  assign bus.o_sw_sec_clk     = oclk_q[OC_SW_SEC];
  assign bus.o_sw_min_clk     = oclk_q[OC_SW_MIN];

endmodule

// File: tb/tb_hms_ctrl.sv
// tb_hms_ctrl: directed and randomized button sequences for hms_ctrl with a
// small state model (mode/position/alarm/stopwatch) and per-window pulse budgets.
module tb_hms_ctrl;

  localparam int SEC_DIV  = 10;
  localparam int SSEC_DIV = 2;
  localparam int DEB      = 4;
  localparam int STEP     = 30;   // cycles per button step (press + release + settle)

  logic clk = 1'b0;
  logic rst_n;

  hms_ctrl_if bus ();

  hms_ctrl #(
    .SEC_DIV    (SEC_DIV),
    .SSEC_DIV   (SSEC_DIV),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // pulse counters: sec, min, hour, a_sec, a_min, a_hour, sw_ssec, sw_sec, sw_min
  int pc [9];
  string oname [9] = '{"sec_clk", "min_clk", "hour_clk", "alarm_sec_clk", "alarm_min_clk",
                       "alarm_hour_clk", "sw_ssec_clk", "sw_sec_clk", "sw_min_clk"};

  // reference state
  int m_mode, m_pos, m_al, m_en;
  int step_no = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.o_sec_clk)        pc[0]++;
      if (bus.o_min_clk)        pc[1]++;
      if (bus.o_hour_clk)       pc[2]++;
      if (bus.o_alarm_sec_clk)  pc[3]++;
      if (bus.o_alarm_min_clk)  pc[4]++;
      if (bus.o_alarm_hour_clk) pc[5]++;
      if (bus.o_sw_ssec_clk)    pc[6]++;
      if (bus.o_sw_sec_clk)     pc[7]++;
      if (bus.o_sw_min_clk)     pc[8]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_mode"}, bus.o_mode, m_mode);
    chk({tag, "_pos"}, bus.o_position, m_pos);
    chk({tag, "_alarm_en"}, bus.o_alarm_en, m_al);
    chk({tag, "_sw_en"}, bus.o_stopwatch_en, m_en);
  endtask

  // btn 0..3 presses that button, 4 presses sw0 and sw1 together
  task automatic do_step(input int btn, input bit bounce);
    logic [3:0] mask;
    int  e [9];
    int  s [9];
    bit  hi;
    bit  chk_sec, chk_ss;
    mask    = (btn == 4) ? 4'b0011 : 4'(1 << btn);
    chk_sec = !(btn == 0 || btn == 4);
    chk_ss  = !(btn == 1 && m_mode == 3);
    // every STEP-cycle window holds STEP/SEC_DIV second ticks and STEP/SSEC_DIV stopwatch ticks
    e[0] = (m_mode != 1 ? STEP / SEC_DIV : 0) + ((btn == 2 && m_mode == 1 && m_pos == 0) ? 1 : 0);
    e[1] = (btn == 2 && m_mode == 1 && m_pos == 1) ? 1 : 0;
    e[2] = (btn == 2 && m_mode == 1 && m_pos == 2) ? 1 : 0;
    e[3] = (btn == 2 && m_mode == 2 && m_pos == 0) ? 1 : 0;
    e[4] = (btn == 2 && m_mode == 2 && m_pos == 1) ? 1 : 0;
    e[5] = (btn == 2 && m_mode == 2 && m_pos == 2) ? 1 : 0;
    e[6] = m_en ? 0 : STEP / SSEC_DIV;
    e[7] = 0;
    e[8] = 0;
    s = pc;
    for (int c = 0; c < STEP; c++) begin
      @(negedge clk);
      hi = bounce ? (c < 2 || (c >= 4 && c < 16)) : (c < 10);
      bus.i_sw = hi ? mask : 4'b0000;
    end
    #1;
    if (btn == 0 || btn == 4) begin
      m_mode = (m_mode + 1) % 4;
      m_pos  = 0;
    end else if (btn == 1) begin
      if (m_mode == 1 || m_mode == 2) m_pos = (m_pos + 1) % 3;
      else if (m_mode == 3)           m_en  = 1 - m_en;
    end else if (btn == 3) begin
      m_al = 1 - m_al;
    end
    for (int k = 0; k < 9; k++) begin
      if ((k != 0 || chk_sec) && (k != 6 || chk_ss))
        chk($sformatf("step%0d_b%0d_%s", step_no, btn, oname[k]), pc[k] - s[k], e[k]);
    end
    chk_state($sformatf("step%0d_b%0d", step_no, btn));
    step_no++;
  endtask

  // raise one wrap flag, expect (or not) a pulse on its downstream clock one cycle later
  task automatic hit_test(input int which, input bit exp);
    int idx;
    int s;
    logic obs;
    idx = (which == 0) ? 1 : (which == 1) ? 2 : (which == 2) ? 7 : 8;
    @(negedge clk);
    case (which)
      0: bus.i_max_hit_sec = 1'b1;
      1: bus.i_max_hit_min = 1'b1;
      2: bus.i_sw_hit_ssec = 1'b1;
      default: bus.i_sw_hit_sec = 1'b1;
    endcase
    @(negedge clk);
    #1;
    case (which)
      0: obs = bus.o_min_clk;
      1: obs = bus.o_hour_clk;
      2: obs = bus.o_sw_sec_clk;
      default: obs = bus.o_sw_min_clk;
    endcase
    chk($sformatf("hit%0d_mode%0d_edge", which, m_mode), obs, exp);
    s = pc[idx];
    repeat (20) @(negedge clk);
    #1;
    chk($sformatf("hit%0d_mode%0d_norepeat", which, m_mode), pc[idx] - s, 0);
    bus.i_max_hit_sec = 1'b0;
    bus.i_max_hit_min = 1'b0;
    bus.i_sw_hit_ssec = 1'b0;
    bus.i_sw_hit_sec  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    int last, n, btn;
    bit seen;
    for (int k = 0; k < 9; k++) pc[k] = 0;
    m_mode = 0; m_pos = 0; m_al = 0; m_en = 1;
    rst_n = 1'b0;
    bus.i_sw = 4'b0000;
    bus.i_max_hit_sec = 1'b0;
    bus.i_max_hit_min = 1'b0;
    bus.i_sw_hit_ssec = 1'b0;
    bus.i_sw_hit_sec  = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk_state("reset");
    chk("reset_sec_clk", bus.o_sec_clk, 0);
    chk("reset_sw_ssec_clk", bus.o_sw_ssec_clk, 0);
    rst_n = 1'b1;

    // idle: second ticks exactly every SEC_DIV cycles, one cycle wide
    last = -1;
    n = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (bus.o_sec_clk === 1'b1) begin
        if (last >= 0) chk("sec_period", c - last, SEC_DIV);
        last = c;
        n++;
      end
    end
    chk("sec_count_in_45", (n >= 4 && n <= 5) ? 1 : 0, 1);
    #1;

    // bouncy mode press, then clean presses around the loop
    do_step(0, 1'b1);
    do_step(0, 1'b0);
    do_step(0, 1'b0);
    do_step(0, 1'b0);
    // SETUP: three increments on seconds, then minutes
    do_step(0, 1'b0);
    do_step(2, 1'b0);
    do_step(2, 1'b1);
    do_step(2, 1'b0);
    do_step(1, 1'b0);
    do_step(2, 1'b0);
    // mode and position pressed together: mode wins
    do_step(4, 1'b0);
    // alarm mode, hour position, increment
    do_step(1, 1'b0);
    do_step(1, 1'b0);
    do_step(2, 1'b0);
    // alarm enable toggled twice
    do_step(3, 1'b0);
    do_step(3, 1'b0);
    // stopwatch: start, stop, leave
    do_step(0, 1'b0);
    do_step(1, 1'b0);
    do_step(2, 1'b0);
    do_step(1, 1'b0);
    do_step(0, 1'b0);

    // carry chain in CLOCK, suppressed in SETUP; stopwatch carries in any mode
    hit_test(0, 1'b1);
    hit_test(1, 1'b1);
    hit_test(2, 1'b1);
    do_step(0, 1'b0);
    hit_test(0, 1'b0);
    hit_test(1, 1'b0);
    hit_test(3, 1'b1);

    // randomized button sequence
    for (int r = 0; r < 30; r++) begin
      btn = $urandom_range(0, 4);
      do_step(btn, 1'(($urandom_range(0, 1))));
    end

    // reset in the middle of a pulse truncates it at once
    if (m_mode == 1) do_step(0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 3 * SEC_DIV && !seen; c++) begin
      @(negedge clk);
      if (bus.o_sec_clk === 1'b1) seen = 1'b1;
    end
    chk("midrst_pulse_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    m_mode = 0; m_pos = 0; m_al = 0; m_en = 1;
    chk("midrst_sec_clk", bus.o_sec_clk, 0);
    chk_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    do_step(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hms_ctrl.md
Name: hms_ctrl

Overview:
- Control front end for the clock/alarm/stopwatch datapath.
- Debounces four pushbuttons and owns the mode and position registers.
- Generates the 1 Hz and 100 Hz ticks and drives every count-clock input of the hour/min/sec counter bank.
- Closes the carry chain by converting the counters' max-hit flags into pulses on the next stage's clock.

Parameters:
- SEC_DIV, 50000000, clk cycles per 1 Hz time-of-day tick.
- SSEC_DIV, 500000, clk cycles per 100 Hz stopwatch tick.
- DEB_CYCLES, 500000, consecutive stable cycles needed to accept a button level.
- REPEAT_DELAY, 25000000, hold time before auto-repeat starts (HOLD_REPEAT_EN only).
- REPEAT_PERIOD, 5000000, auto-repeat interval (HOLD_REPEAT_EN only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- i_sw  in  4  raw pushbuttons, active-high: [0] mode, [1] position / stopwatch start-stop, [2] increment, [3] alarm enable toggle
- i_max_hit_sec  in  1  seconds counter wrap flag
- i_max_hit_min  in  1  minutes counter wrap flag
- i_sw_hit_ssec  in  1  stopwatch 1/100 s wrap flag
- i_sw_hit_sec  in  1  stopwatch seconds wrap flag
- o_mode  out  2  0 CLOCK, 1 SETUP, 2 ALARM, 3 STOPWATCH
- o_position  out  2  0 SEC, 1 MIN, 2 HOUR
- o_alarm_en  out  1  alarm enable
- o_stopwatch_en  out  1  1 = stopped, 0 = running
- o_sec_clk, o_min_clk, o_hour_clk  out  1 each  time-of-day count clocks
- o_alarm_sec_clk, o_alarm_min_clk, o_alarm_hour_clk  out  1 each  alarm count clocks
- o_sw_ssec_clk, o_sw_sec_clk, o_sw_min_clk  out  1 each  stopwatch count clocks

Behaviour:
- Reset values:
  - o_mode=0, o_position=0, o_alarm_en=0, o_stopwatch_en=1.
  - All *_clk outputs 0; tick, debounce and edge registers cleared.
- Ticks:
  - Free-running counter runs 0..SEC_DIV-1; sec_tick is asserted in the cycle the count equals SEC_DIV-1, then the counter wraps to 0.
  - ssec_tick works the same way with SSEC_DIV.
- Debounce, per button:
  - 2-flop synchronizer feeds a stability counter.
  - The debounced level updates after DEB_CYCLES consecutive cycles of a differing synchronized value.
  - A rising debounced edge produces a 1-cycle press pulse.
- Mode and position:
  - sw0 press: mode advances 0→1→2→3→0 and position forces to 0.
  - sw1 press in mode 1 or 2: position advances 0→1→2→0. Value 3 is never produced.
  - sw1 press in mode 3: o_stopwatch_en toggles. Ignored in mode 0.
  - sw3 press: o_alarm_en toggles in any mode.
  - sw2 press is ignored in modes 0 and 3.
- Edge detect: one register per hit input (same clock domain, no synchronizer). A rise is prev=0 and cur=1. Edge registers track continuously in every mode.
- Output clocks:
  - All are registered, high for exactly 1 cycle per event, one cycle after the causing condition.
  - o_sec_clk = (mode≠1 & sec_tick) | (mode=1 & pos=0 & inc).
  - o_min_clk = (mode≠1 & rise(max_hit_sec)) | (mode=1 & pos=1 & inc).
  - o_hour_clk = (mode≠1 & rise(max_hit_min)) | (mode=1 & pos=2 & inc).
  - In SETUP, time is frozen and carries are suppressed.
  - o_alarm_{sec,min,hour}_clk = mode=2 & pos={0,1,2} & inc. No carry.
  - o_sw_ssec_clk = ssec_tick & ~o_stopwatch_en.
  - o_sw_sec_clk = rise(sw_hit_ssec).
  - o_sw_min_clk = rise(sw_hit_sec).
  - Stopwatch pulses are generated in every mode.
- Simultaneous events:
  - All decisions use the registered mode/position before any update in the same cycle.
  - A tick and an increment coinciding on one output give a single pulse.
  - sw0 and sw1 in the same cycle: the mode change wins and position goes to 0.
- Reset mid-operation: every register returns to its reset value immediately. Any in-flight pulse is truncated.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined: while the debounced sw2 stays high, extra inc pulses fire after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles, until release.
- Undefined: exactly one inc per press; REPEAT_* parameters are unused.

Test Plan:
- Reset (SEC_DIV=10, SSEC_DIV=2, DEB_CYCLES=4): o_mode=0, o_position=0, o_alarm_en=0, o_stopwatch_en=1, no sw pulses → o_sec_clk 1-cycle pulses exactly every 10 cycles.
- Bounce: sw0 toggles 1,0,1 every 2 cycles, then held 10 cycles → o_mode 0→1 once; three further clean presses → o_mode 2,3,0.
- SETUP: mode 1, three sw2 presses → exactly 3 o_sec_clk pulses and none from ticks over 50 cycles; sw1 then sw2 → o_position=1, one o_min_clk, no o_sec_clk.
- Carry: mode 0, i_max_hit_sec 0→1 and held → one o_min_clk pulse 1 cycle later, no repeat; same stimulus in mode 1 → no pulse.
- Stopwatch: mode 3 → no o_sw_ssec_clk; sw1 → o_stopwatch_en=0 and pulses every 2 cycles; sw1 → en=1, pulses stop; sw0 → mode 0, en stays 1.
- Alarm: sw3 twice → o_alarm_en 0→1→0; mode 2, position 2, sw2 → one o_alarm_hour_clk, no o_hour_clk.
